// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU: opcode encodings, FSM state
// encodings and a small opcode classification helper.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_SHIFT_ENC = 2'd1;
  localparam logic [1:0] ST_HOLD_ENC  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_SHIFT = ST_SHIFT_ENC,
    ST_HOLD  = ST_HOLD_ENC
  } state_t;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational single-cycle datapath: ADD, SUB, AND, OR, XOR, SLT and
// all flag generation. Shift opcodes pass operand a through unchanged with
// carry=0, which is exactly the result of a shift by zero; non-zero shifts are
// iterated by the parent.
// Ports:
//   i_op        opcode
//   i_a, i_b    operands (two's complement for signed ops)
//   o_result    combinational result
//   o_carry     carry (ADD) / borrow (SUB), else 0
//   o_overflow  signed overflow for ADD/SUB, else 0
//   o_zero      result == 0
//   o_negative  result msb
// -----------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_zero,
  output logic             o_negative
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // Bit WIDTH of the zero-extended difference is set exactly when a < b
  // (unsigned), i.e. it is the borrow.
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_result   = i_a;
    o_carry    = 1'b0;
    o_overflow = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_result   = w_sum[MSB:0];
        o_carry    = w_sum[WIDTH];
        o_overflow = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
      end
      OP_SUB: begin
        o_result   = w_diff[MSB:0];
        o_carry    = w_diff[WIDTH];
        o_overflow = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
      end
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_SLT:  o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      default: o_result = i_a;
    endcase
  end

  assign o_zero     = (o_result == '0);
  assign o_negative = o_result[MSB];

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Handshaked ALU. One operation per input transaction; registered result and
// flags are presented on the output port. Single-cycle ops complete in one
// cycle; SHL/SRA iterate one bit per cycle.
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// where valid && ready are both high. A producer holding valid keeps its
// payload stable until the transfer; in_ready depends only on the FSM state
// and out_ready, never on in_valid. The result/flags are stable while
// out_valid is high and out_ready is low.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   in_valid/in_ready   input handshake
//   op, x, y            opcode and operands (shift amount = y[SW-1:0])
//   out_valid/out_ready output handshake
//   result              registered result
//   carry, overflow,
//   zero, negative      registered flags
//   dbg_state           current FSM state encoding
// -----------------------------------------------------------------------------
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic [1:0]       dbg_state
);

  localparam int SW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_sh;
  logic [SW-1:0]    r_cnt;
  logic             r_sra;

  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_overflow;
  logic             r_zero;
  logic             r_negative;

  logic [SW-1:0]    w_amt;
  logic             w_accept;
  logic             w_start_shift;
  logic             w_last_step;
  logic [WIDTH-1:0] w_step_res;
  logic             w_step_out;

  logic [WIDTH-1:0] w_core_result;
  logic             w_core_carry;
  logic             w_core_overflow;
  logic             w_core_zero;
  logic             w_core_negative;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_op       (op),
    .i_a        (x),
    .i_b        (y),
    .o_result   (w_core_result),
    .o_carry    (w_core_carry),
    .o_overflow (w_core_overflow),
    .o_zero     (w_core_zero),
    .o_negative (w_core_negative)
  );

  assign w_amt         = y[SW-1:0];
  // A zero-amount shift is handled by the core as a pass-through, so only
  // non-zero shifts enter the iterative path.
  assign w_start_shift = is_shift(op) && (w_amt != '0);
  assign w_accept      = in_valid &&
                         ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready));
  assign w_last_step   = (r_state == ST_SHIFT) && (r_cnt == SW'(1));

  assign w_step_res = r_sra ? {r_sh[MSB], r_sh[MSB:1]} : {r_sh[MSB-1:0], 1'b0};
  assign w_step_out = r_sra ? r_sh[0] : r_sh[MSB];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next state and handshake outputs
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = w_start_shift ? ST_SHIFT : ST_HOLD;
      end
      ST_SHIFT: begin
        if (r_cnt == SW'(1)) w_next = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) w_next = w_start_shift ? ST_SHIFT : ST_HOLD;
          else          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Shift engine and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh       <= '0;
      r_cnt      <= '0;
      r_sra      <= 1'b0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
    end else if (w_accept) begin
      if (w_start_shift) begin
        r_sh  <= x;
        r_cnt <= w_amt;
        r_sra <= (op == OP_SRA);
      end else begin
        r_result   <= w_core_result;
        r_carry    <= w_core_carry;
        r_overflow <= w_core_overflow;
        r_zero     <= w_core_zero;
        r_negative <= w_core_negative;
      end
    end else if (r_state == ST_SHIFT) begin
      if (w_last_step) begin
        r_result   <= w_step_res;
        r_carry    <= w_step_out;
        r_overflow <= 1'b0;
        r_zero     <= (w_step_res == '0);
        r_negative <= w_step_res[MSB];
      end else begin
        r_sh  <= w_step_res;
        r_cnt <= r_cnt - SW'(1);
      end
    end
  end

  assign result    = r_result;
  assign carry     = r_carry;
  assign overflow  = r_overflow;
  assign zero      = r_zero;
  assign negative  = r_negative;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
// Directed self-checking bench for seq_alu (WIDTH=8). Inputs are driven on the
// falling edge, outputs are sampled on the falling edge (away from the active
// rising edge). Observed vector is {out_valid, result, C, V, Z, N}.
// -----------------------------------------------------------------------------
module tb_seq_alu;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;
  logic         zero;
  logic         negative;
  logic [1:0]   dbg_state;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [12:0] act;
  assign act = {out_valid, result, carry, overflow, zero, negative};

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- expected-value builder and driver ----------------
  function automatic logic [12:0] ev(input logic v, input logic [7:0] r,
                                     input logic c, input logic vf,
                                     input logic z, input logic n);
    return {v, r, c, vf, z, n};
  endfunction

  task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] a,
                       input logic [7:0] b, input logic ordy);
    in_valid  = v;
    op        = o;
    x         = a;
    y         = b;
    out_ready = ordy;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (act !== 13'h0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got %h want %h", act, 13'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if ({in_ready, dbg_state} !== 3'b100) begin
      err_cnt++;
      $display("FAIL reset_idle: in_ready/state got %b want 100", {in_ready, dbg_state});
    end
  endtask

  logic [2:0]  t_op  [7] = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b010, 3'b011, 3'b101};
  logic [7:0]  t_x   [7] = '{8'h7F, 8'h80, 8'h00, 8'hFF, 8'hF0, 8'h0F, 8'h01};
  logic [7:0]  t_y   [7] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h3C, 8'h80, 8'h80};
  logic [12:0] t_exp [7];

  task automatic test_single_cycle_ops();
    t_exp[0] = ev(1, 8'h80, 0, 1, 0, 1);  // ADD 7F+01
    t_exp[1] = ev(1, 8'h7F, 0, 1, 0, 0);  // SUB 80-01
    t_exp[2] = ev(1, 8'hFF, 1, 0, 0, 1);  // SUB 00-01
    t_exp[3] = ev(1, 8'h00, 1, 0, 1, 0);  // ADD FF+01
    t_exp[4] = ev(1, 8'h30, 0, 0, 0, 0);  // AND
    t_exp[5] = ev(1, 8'h8F, 0, 0, 0, 1);  // OR
    t_exp[6] = ev(1, 8'h00, 0, 0, 1, 0);  // SLT 1 < -128 is false
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, t_op[i], t_x[i], t_y[i], 1'b1);
      #1;
      vec_cnt++;
      if (in_ready !== 1'b1) begin
        err_cnt++;
        $display("FAIL op%0d_in_ready: got %b want 1", i, in_ready);
      end
      @(negedge clk);
      drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b1);
      vec_cnt++;
      if (act !== t_exp[i]) begin
        err_cnt++;
        $display("FAIL op%0d_result: got %h want %h", i, act, t_exp[i]);
      end
      @(negedge clk);
      vec_cnt++;
      if (out_valid !== 1'b0) begin
        err_cnt++;
        $display("FAIL op%0d_valid_drop: got %b want 0", i, out_valid);
      end
    end
  endtask

  task automatic shift_case(input string name, input logic [2:0] o,
                            input logic [7:0] a, input logic [7:0] b,
                            input int n, input logic [12:0] exp_v);
    drive(1'b1, o, a, b, 1'b1);
    @(negedge clk);
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b1);
    for (int k = 0; k < n; k++) begin
      #1;
      vec_cnt++;
      if ({out_valid, in_ready} !== 2'b00) begin
        err_cnt++;
        $display("FAIL %s_busy%0d: valid/ready got %b want 00", name, k, {out_valid, in_ready});
      end
      @(negedge clk);
    end
    vec_cnt++;
    if (act !== exp_v) begin
      err_cnt++;
      $display("FAIL %s_result: got %h want %h", name, act, exp_v);
    end
    @(negedge clk);
    vec_cnt++;
    if (out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s_valid_drop: got %b want 0", name, out_valid);
    end
  endtask

  task automatic test_shifts();
    shift_case("shl3",   3'b110, 8'h81, 8'h03, 3, ev(1, 8'h08, 0, 0, 0, 0));
    shift_case("sra7",   3'b111, 8'h80, 8'h07, 7, ev(1, 8'hFF, 0, 0, 0, 1));
    shift_case("shl0",   3'b110, 8'h81, 8'h00, 0, ev(1, 8'h81, 0, 0, 0, 1));
    shift_case("shl1",   3'b110, 8'h81, 8'h01, 1, ev(1, 8'h02, 1, 0, 0, 0));
    shift_case("sra1",   3'b111, 8'h05, 8'h01, 1, ev(1, 8'h02, 1, 0, 0, 0));
    // Only y[2:0] is the amount: 0x0A shifts by 2
    shift_case("sra_hi", 3'b111, 8'h7F, 8'h0A, 2, ev(1, 8'h1F, 1, 0, 0, 0));
    shift_case("shl_z",  3'b110, 8'h80, 8'h01, 1, ev(1, 8'h00, 1, 0, 1, 0));
  endtask

  task automatic test_backpressure();
    logic [12:0] held;
    held = ev(1, 8'h20, 1, 1, 0, 0);  // ADD 90+90 = 0x120
    drive(1'b1, 3'b000, 8'h90, 8'h90, 1'b0);
    @(negedge clk);
    drive(1'b1, 3'b100, 8'hF0, 8'hFF, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      vec_cnt++;
      if ({act, in_ready} !== {held, 1'b0}) begin
        err_cnt++;
        $display("FAIL hold%0d: got %h/%b want %h/0", k, act, in_ready, held);
      end
      @(negedge clk);
    end
    drive(1'b1, 3'b100, 8'hF0, 8'hFF, 1'b1);
    #1;
    vec_cnt++;
    if (in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL hold_release_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b1);
    vec_cnt++;
    if (act !== ev(1, 8'h0F, 0, 0, 0, 0)) begin
      err_cnt++;
      $display("FAIL hold_xor: got %h want %h", act, ev(1, 8'h0F, 0, 0, 0, 0));
    end
    @(negedge clk);
    vec_cnt++;
    if (out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL hold_valid_drop: got %b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  b_op  [3];
    logic [7:0]  b_x   [3];
    logic [7:0]  b_y   [3];
    logic [12:0] b_exp [3];
    b_op[0] = 3'b000; b_x[0] = 8'h10; b_y[0] = 8'h20; b_exp[0] = ev(1, 8'h30, 0, 0, 0, 0);
    b_op[1] = 3'b001; b_x[1] = 8'h05; b_y[1] = 8'h07; b_exp[1] = ev(1, 8'hFE, 1, 0, 0, 1);
    b_op[2] = 3'b101; b_x[2] = 8'h80; b_y[2] = 8'h01; b_exp[2] = ev(1, 8'h01, 0, 0, 0, 0);
    drive(1'b1, b_op[0], b_x[0], b_y[0], 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) drive(1'b1, b_op[i+1], b_x[i+1], b_y[i+1], 1'b1);
      else       drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b1);
      vec_cnt++;
      if (act !== b_exp[i]) begin
        err_cnt++;
        $display("FAIL b2b%0d: got %h want %h", i, act, b_exp[i]);
      end
    end
    @(negedge clk);
    vec_cnt++;
    if (out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL b2b_valid_drop: got %b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_shift();
    drive(1'b1, 3'b110, 8'h81, 8'h05, 1'b1);
    @(negedge clk);
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    rst = 1'b1;  // second SHIFT cycle
    #1;
    vec_cnt++;
    if ({act, dbg_state} !== 15'h0) begin
      err_cnt++;
      $display("FAIL mid_shift_reset: got %h/%b want 0/00", act, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      vec_cnt++;
      if ({out_valid, in_ready} !== 2'b01) begin
        err_cnt++;
        $display("FAIL no_stale%0d: valid/ready got %b want 01", k, {out_valid, in_ready});
      end
    end
    drive(1'b1, 3'b011, 8'h01, 8'h02, 1'b1);
    @(negedge clk);
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b1);
    vec_cnt++;
    if (act !== ev(1, 8'h03, 0, 0, 0, 0)) begin
      err_cnt++;
      $display("FAIL post_reset_op: got %h want %h", act, ev(1, 8'h03, 0, 0, 0, 0));
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_cycle_ops();
    test_shifts();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the team's 8-bit add/subtract unit. Accepts one operation per transaction over a valid/ready input port. Presents a registered result plus carry/overflow/zero/negative flags over a valid/ready output port. Single-cycle ops take one cycle; shifts iterate one bit per cycle under a small FSM. Sits between an operand source (register file or testbench driver) and a result consumer.

## Interface
- WIDTH, 8: operand/result width; power of two, ≥4.
- SW, $clog2(WIDTH): shift-amount width (derived, not overridden).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept this cycle.
- op  in  3  operation code (see Operation).
- x, y  in  WIDTH  operands, two's complement for signed ops.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes result this cycle.
- result  out  WIDTH  registered result.
- carry, overflow, zero, negative  out  1 each  registered flags.

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed x<y → result 1, else 0), 110 SHL (x << y[SW-1:0]), 111 SRA (x >>> y[SW-1:0], sign-filling).
- ADD: {carry,result} = x+y (WIDTH+1 bits); overflow = (x[msb]==y[msb]) && (result[msb]!=x[msb]).
- SUB: result = x−y mod 2^WIDTH; carry = borrow (x<y unsigned); overflow = (x[msb]!=y[msb]) && (result[msb]!=x[msb]).
- AND/OR/XOR/SLT: carry=0, overflow=0.
- SHL/SRA: carry = last bit shifted out (0 when amount=0); overflow=0.
- All ops: zero = (result==0); negative = result[msb].
- States: IDLE, SHIFT, HOLD. Reset → IDLE.
- IDLE: in_ready=1. On accept (in_valid&&in_ready), op, x, y and the shift amount are latched. Non-shift op or shift amount 0 → HOLD with result/flags loaded. Shift with amount n>0 → SHIFT, counter=n.
- SHIFT: in_ready=0, out_valid=0; one bit per cycle; counter decrements; at counter==1 the final step loads result/flags → HOLD.
- HOLD: out_valid=1; result/flags stable until out_ready. in_ready = out_ready.
  - out_ready && in_valid: new op accepted in the same cycle, taking the IDLE branch. out_valid stays 1 for a single-cycle op; goes 0 for a shift op with n>0.
  - out_ready && !in_valid → IDLE.
- Input changes after accept are ignored.

## Timing
- Reset values: out_valid=0, result=0, carry=overflow=zero=negative=0; in_ready=1 once rst deasserts.
- rst asserted in any state (incl. mid-SHIFT) → IDLE immediately; the in-flight op is discarded.
- Latency from accept edge to out_valid: 1 cycle for single-cycle ops and zero-amount shifts; n+1 cycles for a shift by n.
- Throughput: one single-cycle op per clock when out_ready is held high.
- in_ready is combinational from state and out_ready only; there is no path from in_valid.
- Outputs are registered; no combinational path from x, y or op to result.

## Structure
- Package alu_pkg: opcode localparams (OP_ADD…OP_SRA), state encoding localparams.
- Sub-module alu_core: purely combinational single-cycle datapath (ADD/SUB/logic/SLT plus all flag generation). seq_alu instantiates it and owns the FSM, shift register, counter and output registers.

## Test plan
- WIDTH=8, ADD 0x7F+0x01 → result 0x80, V=1, N=1, C=0, Z=0; out_valid exactly 1 cycle after accept.
- SUB 0x80−0x01 → 0x7F, V=1, C=0. SUB 0x00−0x01 → 0xFF, C=1, N=1, V=0. ADD 0xFF+0x01 → 0x00, C=1, Z=1.
- SHL x=0x81, y=3 → 0x08, C=0, out_valid 4 cycles after accept, in_ready low throughout. SRA x=0x80, y=7 → 0xFF, N=1, 8-cycle latency. SHL y=0 → 0x81 in 1 cycle, C=0.
- Back-pressure: hold out_ready=0 for 5 cycles in HOLD → result/flags unchanged, in_ready=0. Then out_ready=1 with in_valid=1 (XOR 0xF0^0xFF) → 0x0F next cycle, out_valid continuous.
- Back-to-back: ADD, SUB and SLT (0x80 vs 0x01 → 1) streamed with out_ready=1 → one result per cycle, in order.
- Assert rst in the 2nd SHIFT cycle of SHL by 5 → out_valid=0, all outputs 0. Next op after release completes normally; no stale result appears.
